// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq -- sequential multiply/divide unit with architectural HI/LO.
//
// One shared datapath performs an iterative shift-add multiply or a restoring
// divide, one bit per cycle. Flow: IDLE -> PREP -> CALC (DATA_W cycles) -> FIX.
// Result is committed to HI/LO at the FIX->IDLE edge, with done pulsed for
// the following cycle. MTLO/MTHI write directly at the accept edge.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready request handshake, transfer when both high at an edge
//   req_op[2:0]         0 MULU, 1 MULS, 2 DIVU, 3 DIVS, 4 MTLO, 5 MTHI, 6-7 ignored
//   data1, data2        multiplicand/dividend/MT source, multiplier/divisor
//   flush               abort the in-flight operation (no commit, no done)
//   busy                high whenever not IDLE
//   done                one-cycle pulse after a MUL/DIV commit
//   reg_lo, reg_hi      architectural LO/HI
module alu_muldiv_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] reg_lo,
    output logic [DATA_W-1:0] reg_hi
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]        state;
    logic              op_div;     // 1 = divide, 0 = multiply
    logic              sign1, sign2;
    logic [DATA_W-1:0] d1_q, d2_q; // raw operands, kept for div-by-zero HI
    logic [DATA_W-1:0] opb;        // multiplicand (MUL) or divisor (DIV)
    logic [DATA_W-1:0] acc;        // product high half / partial remainder
    logic [DATA_W-1:0] qreg;       // multiplier shifting out / quotient shifting in
    logic [CNT_W-1:0]  cnt;

    assign busy      = (state != S_IDLE);
    assign req_ready = (state == S_IDLE) & ~flush;

    // Magnitudes; sign flags are only ever set for signed ops.
    logic [DATA_W-1:0] mag1, mag2;
    assign mag1 = sign1 ? (~d1_q + 1'b1) : d1_q;
    assign mag2 = sign2 ? (~d2_q + 1'b1) : d2_q;

    // Multiply step: conditional add, then shift {sum, qreg} right by one.
    logic [DATA_W:0] mul_sum;
    assign mul_sum = {1'b0, acc} + (qreg[0] ? {1'b0, opb} : {(DATA_W+1){1'b0}});

    // Restoring divide step: shift in next dividend bit, trial subtract.
    // Bit DATA_W of the trial is the borrow (remainder stays below 2*divisor).
    logic [DATA_W:0] div_shift, div_trial;
    assign div_shift = {acc, qreg[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, opb};

    // Final sign fix-up.
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]   quo_s, rem_s;
    logic                div_zero;
    assign prod     = {acc, qreg};
    assign prod_s   = (sign1 ^ sign2) ? (~prod + 1'b1) : prod;
    assign quo_s    = (sign1 ^ sign2) ? (~qreg + 1'b1) : qreg;
    assign rem_s    = sign1 ? (~acc + 1'b1) : acc;
    assign div_zero = (d2_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_div <= 1'b0;
            sign1  <= 1'b0;
            sign2  <= 1'b0;
            d1_q   <= '0;
            d2_q   <= '0;
            opb    <= '0;
            acc    <= '0;
            qreg   <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            reg_lo <= '0;
            reg_hi <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        case (req_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                d1_q   <= data1;
                                d2_q   <= data2;
                                op_div <= req_op[1];
                                sign1  <= req_op[0] & data1[DATA_W-1];
                                sign2  <= req_op[0] & data2[DATA_W-1];
                                state  <= S_PREP;
                            end
                            3'd4:    reg_lo <= data1;
                            3'd5:    reg_hi <= data1;
                            default: ;
                        endcase
                    end
                end
                S_PREP: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        // Divide shifts the dividend; multiply shifts the multiplier.
                        qreg  <= op_div ? mag1 : mag2;
                        opb   <= op_div ? mag2 : mag1;
                        acc   <= '0;
                        cnt   <= CNT_INIT;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (op_div) begin
                            if (!div_trial[DATA_W]) begin
                                acc  <= div_trial[DATA_W-1:0];
                                qreg <= {qreg[DATA_W-2:0], 1'b1};
                            end else begin
                                acc  <= div_shift[DATA_W-1:0];
                                qreg <= {qreg[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            {acc, qreg} <= {mul_sum, qreg[DATA_W-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    // flush wins over the commit
                    if (!flush) begin
                        done <= 1'b1;
                        if (!op_div) begin
                            {reg_hi, reg_lo} <= prod_s;
                        end else if (div_zero) begin
                            reg_lo <= '1;
                            reg_hi <= d1_q;
                        end else begin
                            reg_lo <= quo_s;
                            reg_hi <= rem_s;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq (DATA_W = 32): a table of hand-computed
// MUL/DIV results, then sequences for back-to-back issue, MT ops, reserved
// ops, flush in CALC and FIX, and asynchronous reset mid-operation.
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] data1, data2;
    logic        flush;
    logic        busy, done;
    logic [31:0] reg_lo, reg_hi;

    alu_muldiv_seq #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .data1(data1), .data2(data2), .flush(flush),
        .busy(busy), .done(done), .reg_lo(reg_lo), .reg_hi(reg_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d1, d2, hi, lo;
    } vec_t;

    vec_t tv[12];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after the accept edge. Counts busy samples and edges to done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Called #1 after an edge while idle; issues one request.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        req_op = op; data1 = a; data2 = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(lat, bcnt);
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
        req_op = op; data1 = a; data2 = '0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;

        tv[0]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tv[1]  = '{3'd0, 32'h00001234, 32'h00005678, 32'h00000000, 32'h06260060};
        tv[2]  = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tv[3]  = '{3'd1, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        tv[4]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tv[5]  = '{3'd2, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        tv[6]  = '{3'd2, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        tv[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tv[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tv[9]  = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        tv[10] = '{3'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        tv[11] = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; data1 = '0; data2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_lo", 64'(reg_lo), 64'h0);
        chk("reset_hi", 64'(reg_hi), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;

        // Table-driven MUL/DIV vectors
        for (int i = 0; i < 12; i++) begin
            run_op(tv[i].op, tv[i].d1, tv[i].d2, lat, bcnt);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd34);
            chk($sformatf("v%0d_hi", i), 64'(reg_hi), 64'(tv[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(reg_lo), 64'(tv[i].lo));
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'h1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'h0);
        end

        // Back-to-back: MULS -3 x 5, then DIVS -7 / 2 with zero idle gap
        req_op = 3'd1; data1 = 32'hFFFFFFFD; data2 = 32'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 3'd3; data1 = 32'hFFFFFFF9; data2 = 32'd2; // next request held pending
        chk("b2b_ready_busy", 64'(req_ready), 64'h0);
        wait_done(lat, bcnt);
        chk("b2b_muls_latency", 64'(lat), 64'd34);
        chk("b2b_muls_hi", 64'(reg_hi), 64'hFFFFFFFF);
        chk("b2b_muls_lo", 64'(reg_lo), 64'hFFFFFFF1);
        chk("b2b_ready_after_done", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_divs_accepted", 64'(busy), 64'h1);
        wait_done(lat, bcnt);
        chk("b2b_divs_latency", 64'(lat), 64'd34);
        chk("b2b_divs_lo", 64'(reg_lo), 64'hFFFFFFFD);
        chk("b2b_divs_hi", 64'(reg_hi), 64'hFFFFFFFF);
        @(posedge clk); #1;

        // MTLO / MTHI
        mt_op(3'd4, 32'h0000AAAA);
        chk("mtlo_lo", 64'(reg_lo), 64'hAAAA);
        chk("mtlo_busy", 64'(busy), 64'h0);
        chk("mtlo_done", 64'(done), 64'h0);
        mt_op(3'd5, 32'h00001234);
        chk("mthi_hi", 64'(reg_hi), 64'h1234);
        chk("mthi_lo_kept", 64'(reg_lo), 64'hAAAA);
        chk("mthi_done", 64'(done), 64'h0);

        // Reserved op: accepted, ignored
        mt_op(3'd6, 32'h0000FFFF);
        chk("rsvd_hi", 64'(reg_hi), 64'h1234);
        chk("rsvd_lo", 64'(reg_lo), 64'hAAAA);
        chk("rsvd_busy", 64'(busy), 64'h0);
        chk("rsvd_done", 64'(done), 64'h0);
        chk("rsvd_ready", 64'(req_ready), 64'h1);

        // Flush in CALC cycle 10 of a MULU, prior HI/LO = 5/6
        mt_op(3'd4, 32'd6);
        mt_op(3'd5, 32'd5);
        req_op = 3'd0; data1 = 32'hFFFFFFFF; data2 = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        #1 chk("flush_calc_ready", 64'(req_ready), 64'h0);
        @(posedge clk); #1;
        chk("flush_calc_idle", 64'(busy), 64'h0);
        flush = 1'b0;
        chk("flush_calc_hi", 64'(reg_hi), 64'd5);
        chk("flush_calc_lo", 64'(reg_lo), 64'd6);
        count_done(40, dcnt);
        chk("flush_calc_no_done", 64'(dcnt), 64'h0);

        // Flush coinciding with FIX: no commit
        req_op = 3'd2; data1 = 32'd100; data2 = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (33) @(posedge clk);
        #1 flush = 1'b1;
        chk("flush_fix_busy", 64'(busy), 64'h1);
        @(posedge clk); #1;
        chk("flush_fix_idle", 64'(busy), 64'h0);
        chk("flush_fix_done", 64'(done), 64'h0);
        chk("flush_fix_ready_low", 64'(req_ready), 64'h0);
        flush = 1'b0;
        #1 chk("flush_fix_ready_high", 64'(req_ready), 64'h1);
        chk("flush_fix_hi", 64'(reg_hi), 64'd5);
        chk("flush_fix_lo", 64'(reg_lo), 64'd6);
        count_done(5, dcnt);
        chk("flush_fix_no_done", 64'(dcnt), 64'h0);

        // Asynchronous reset mid-DIVU
        req_op = 3'd2; data1 = 32'd100; data2 = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_lo", 64'(reg_lo), 64'h0);
        chk("areset_hi", 64'(reg_hi), 64'h0);
        chk("areset_busy", 64'(busy), 64'h0);
        chk("areset_done", 64'(done), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("areset_ready", 64'(req_ready), 64'h1);
        count_done(40, dcnt);
        chk("areset_no_done", 64'(dcnt), 64'h0);
        chk("areset_idle", 64'(busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and HI/LO width; CNT_W = ceil(log2(DATA_W+1)), derived, not overridable.
REQ-002 SHALL have clk  in  1  sole clock, rising edge.
REQ-003 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  in  1  request present.
REQ-005 SHALL have req_ready  out  1  block can accept; transfer = req_valid & req_ready at a rising edge.
REQ-006 SHALL have req_op  in  3  0 MULU, 1 MULS, 2 DIVU, 3 DIVS, 4 MTLO, 5 MTHI, 6-7 reserved.
REQ-007 SHALL have data1  in  DATA_W  multiplicand / dividend / MT source.
REQ-008 SHALL have data2  in  DATA_W  multiplier / divisor.
REQ-009 SHALL have flush  in  1  abort the in-flight operation.
REQ-010 SHALL have busy  out  1  high whenever state != IDLE.
REQ-011 SHALL have done  out  1  one-cycle pulse when a MUL/DIV result commits.
REQ-012 SHALL have reg_lo  out  DATA_W  architectural LO, registered.
REQ-013 SHALL have reg_hi  out  DATA_W  architectural HI, registered.

Function
REQ-014 SHALL implement the FSM IDLE -> PREP -> CALC -> FIX -> IDLE, with one shared iterative shift-add multiplier and restoring divider, one bit per cycle.
REQ-015 SHALL drive req_ready = (state == IDLE) & ~flush.
REQ-016 SHALL, on a MUL/DIV transfer, latch the operands, op, and the sign flags (signed ops only), and enter PREP.
REQ-017 SHALL, in PREP, replace signed operands with their magnitudes (unsigned, DATA_W bits), clear the accumulator, load the counter with DATA_W, and go to CALC.
REQ-018 SHALL, in CALC, process one bit per cycle and decrement the counter, going to FIX when the counter reaches 1 at an edge; CALC SHALL last exactly DATA_W cycles.
REQ-019 SHALL, in FIX, apply signs, write HI/LO at the FIX->IDLE edge, and assert done for the following cycle.
REQ-020 SHALL give latency from accept edge E0 to HI/LO visible = DATA_W+2 edges, with done high in that same cycle; 34 for DATA_W=32.
REQ-021 SHALL, for MUL, produce a 2*DATA_W product with HI = upper half and LO = lower half; MULS SHALL negate the full 2*DATA_W magnitude product when the operand signs differ.
REQ-022 SHALL, for DIV, set LO = quotient and HI = remainder; for DIVS, quotient sign = sign1 ^ sign2 and remainder sign = dividend sign.
REQ-023 SHALL, for divisor == 0 (DIVU or DIVS), run full latency and force LO = all ones and HI = the original data1.
REQ-024 SHALL, for DIVS of most-negative / -1, yield LO = most-negative and HI = 0, with no special flag.
REQ-025 SHALL, for MTLO/MTHI, write data1 to LO/HI at the accept edge, stay in IDLE, and assert no done.
REQ-026 SHALL accept reserved ops and otherwise ignore them: no state change, no write.
REQ-027 SHALL, when flush is high in PREP, CALC or FIX, return to IDLE at the next edge with HI/LO unchanged and no done; flush has priority over the FIX commit.
REQ-028 SHALL hold req_ready low while busy so the requester keeps req_valid asserted; a new request SHALL be accepted in the first IDLE cycle, so back-to-back gap = 0 cycles after done.
REQ-029 SHALL clear done in every cycle other than the one following a commit.

Reset
REQ-030 SHALL, while rst_n is low, asynchronously force state = IDLE, reg_lo = 0, reg_hi = 0, done = 0, busy = 0, and counter/accumulator = 0.
REQ-031 SHALL, when reset asserts mid-operation, discard the operation with no done after release; req_ready SHALL be high in the first cycle after release if flush is low.

Verification
REQ-032 SHALL cover: MULU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 34 edges after accept, busy high for 34 cycles.
REQ-033 SHALL cover: MULS -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIVS -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, issued back-to-back with zero idle gap.
REQ-034 SHALL cover: DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007; DIVS 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL cover: MTHI 0x1234 with LO=0xAAAA -> reg_hi=0x1234 after one edge, reg_lo unchanged, done never asserted.
REQ-036 SHALL cover: flush in CALC cycle 10 of MULU with prior HI/LO = 5/6 -> IDLE next edge, HI/LO stay 5/6, no done; flush coinciding with FIX -> no commit.
REQ-037 SHALL cover: rst_n low asynchronously mid-DIVU (between edges) -> reg_lo = reg_hi = 0 and busy = 0 immediately, no done after release.
